dsp_mac_pipe: RTL and testbench

- Parametrised behavioural pre-adder multiply-accumulate slice; next generation of the team's fixed DSP wrapper.
- Adds the following features:
  - configurable operand widths and multiplier pipeline depth;
  - runtime op-mode select, including true accumulation;
  - a valid pipeline;
  - optional saturation with an overflow flag.
- Used as the PE arithmetic core in the systolic array. Cascades slice-to-slice through pcin/pcout.

---
 rtl/dsp_mac_pipe.sv | 181 ++++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: pre-adder multiply-accumulate slice with an optional product
// register, runtime op-mode select, valid pipeline and optional saturation.
//
// Ports:
//   clk, rst        rising-edge clock; asynchronous active-low reset
//   enable          global clock enable, freezes every register when low
//   in_valid        a/d/b/c/mode/acc_clr are valid this cycle
//   a, d (A_W)      signed operand and signed pre-adder operand
//   b (B_W)         signed multiplier operand
//   c (P_W)         signed addend
//   pcin (P_W)      cascade input, sampled at the final stage
//   mode (3)        0:(a+d)*b+c 1:(a-d)*b+c 2:a*b+pcin 3:a*b+p 4:(a+d)*b+pcin
//                   5-7 reserved: result is c
//   acc_clr         with mode 3, accumulate onto 0 instead of p
//   out_valid       p/pcout/overflow carry a new result
//   p, pcout (P_W)  signed result; pcout mirrors p for the downstream slice
//   overflow        the last valid result left the P_W signed range
module dsp_mac_pipe #(
  parameter int A_W      = 27,
  parameter int B_W      = 18,
  parameter int P_W      = 48,
  parameter int M_REG    = 1,
  parameter int SATURATE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           in_valid,
  input  logic [A_W-1:0] a,
  input  logic [A_W-1:0] d,
  input  logic [B_W-1:0] b,
  input  logic [P_W-1:0] c,
  input  logic [P_W-1:0] pcin,
  input  logic [2:0]     mode,
  input  logic           acc_clr,
  output logic           out_valid,
  output logic [P_W-1:0] p,
  output logic [P_W-1:0] pcout,
  output logic           overflow
);

  localparam int PR_W = A_W + B_W + 1;
  localparam int S_W  = P_W + 2;

  if (PR_W > P_W + 1) begin : g_width_check
    $error("dsp_mac_pipe: A_W+B_W+1 must not exceed P_W+1");
  end

  typedef enum logic [2:0] {
    MODE_ADD_C    = 3'd0,
    MODE_SUB_C    = 3'd1,
    MODE_A_PCIN   = 3'd2,
    MODE_ACC      = 3'd3,
    MODE_ADD_PCIN = 3'd4
  } mode_t;

  // Stage 1: input register
  logic [A_W-1:0] a1, d1;
  logic [B_W-1:0] b1;
  logic [P_W-1:0] c1;
  logic [2:0]     m1;
  logic           clr1, v1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a1   <= '0;
      d1   <= '0;
      b1   <= '0;
      c1   <= '0;
      m1   <= '0;
      clr1 <= 1'b0;
      v1   <= 1'b0;
    end else if (enable) begin
      a1   <= a;
      d1   <= d;
      b1   <= b;
      c1   <= c;
      m1   <= mode;
      clr1 <= acc_clr;
      v1   <= in_valid;
    end
  end

  // Stage 2: pre-adder at A_W+1 bits, then product at A_W+B_W+1 bits.
  // Reserved modes force the pre-adder to 0 so the result reduces to c.
  logic [A_W:0] a_x, d_x, pre;
  assign a_x = {a1[A_W-1], a1};
  assign d_x = {d1[A_W-1], d1};

  always_comb begin
    pre = '0;
    case (m1)
      MODE_ADD_C, MODE_ADD_PCIN: pre = a_x + d_x;
      MODE_SUB_C:                pre = a_x - d_x;
      MODE_A_PCIN, MODE_ACC:     pre = a_x;
      default:                   pre = '0;
    endcase
  end

  // Both operands sign-extended to the full product width; the low PR_W bits
  // of the unsigned product are then the exact signed product.
  logic [PR_W-1:0] pre_e, b_e, prod;
  assign pre_e = {{B_W{pre[A_W]}}, pre};
  assign b_e   = {{(A_W + 1){b1[B_W-1]}}, b1};
  assign prod  = pre_e * b_e;

  logic [PR_W-1:0] prod2;
  logic [P_W-1:0]  c2;
  logic [2:0]      m2;
  logic            clr2, v2;

  if (M_REG != 0) begin : g_mreg
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        prod2 <= '0;
        c2    <= '0;
        m2    <= '0;
        clr2  <= 1'b0;
        v2    <= 1'b0;
      end else if (enable) begin
        prod2 <= prod;
        c2    <= c1;
        m2    <= m1;
        clr2  <= clr1;
        v2    <= v1;
      end
    end
  end else begin : g_mcomb
    assign prod2 = prod;
    assign c2    = c1;
    assign m2    = m1;
    assign clr2  = clr1;
    assign v2    = v1;
  end

  // Final stage: addend select, widened sum, range check.
  logic [P_W-1:0] p_q, addend, res;
  logic [S_W-1:0] sum;
  logic           ovf, ovf_q, vout_q;

  always_comb begin
    addend = c2;
    case (m2)
      MODE_ADD_C, MODE_SUB_C:     addend = c2;
      MODE_A_PCIN, MODE_ADD_PCIN: addend = pcin;
      MODE_ACC:                   addend = clr2 ? '0 : p_q;
      default:                    addend = c2;
    endcase
  end

  assign sum = {{(S_W - PR_W){prod2[PR_W-1]}}, prod2} + {{2{addend[P_W-1]}}, addend};

  // In range iff the three bits from the P_W sign bit upward all agree.
  assign ovf = !((sum[S_W-1:P_W-1] == '0) || (sum[S_W-1:P_W-1] == '1));

  always_comb begin
    res = sum[P_W-1:0];
    if (SATURATE != 0 && ovf)
      res = sum[S_W-1] ? {1'b1, {(P_W - 1){1'b0}}} : {1'b0, {(P_W - 1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q    <= '0;
      ovf_q  <= 1'b0;
      vout_q <= 1'b0;
    end else if (enable) begin
      vout_q <= v2;
      if (v2) begin
        p_q   <= res;
        ovf_q <= ovf;
      end
    end
  end

  assign p         = p_q;
  assign pcout     = p_q;
  assign overflow  = ovf_q;
  assign out_valid = vout_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
module tb_dsp_mac_pipe;
  localparam int AW = 27, BW = 18, PW = 48;
  localparam int SA = 8, SB = 8, SP = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  // default-width group: u_dflt (M_REG=1, also cascade upstream) and u_m0 (M_REG=0)
  logic                 iv, clr;
  logic [2:0]           mode;
  logic signed [AW-1:0] a, d;
  logic signed [BW-1:0] b;
  logic signed [PW-1:0] c, pcin;
  logic signed [PW-1:0] d_p, d_pc, m0_p, m0_pc;
  logic                 d_ov, d_vo, m0_ov, m0_vo;

  // cascade downstream
  logic                 dn_iv, dn_clr;
  logic [2:0]           dn_mode;
  logic signed [AW-1:0] dn_a, dn_d;
  logic signed [BW-1:0] dn_b;
  logic signed [PW-1:0] dn_c, dn_p, dn_pc;
  logic                 dn_ov, dn_vo;

  // narrow saturation group
  logic                 siv, sclr;
  logic [2:0]           smode;
  logic signed [SA-1:0] sa, sd;
  logic signed [SB-1:0] sb;
  logic signed [SP-1:0] sc, spcin, s1_p, s1_pc, s0_p, s0_pc;
  logic                 s1_ov, s1_vo, s0_ov, s0_vo;

  dsp_mac_pipe #(.A_W(AW), .B_W(BW), .P_W(PW), .M_REG(1), .SATURATE(0)) u_dflt (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(iv), .a(a), .d(d), .b(b),
    .c(c), .pcin(pcin), .mode(mode), .acc_clr(clr), .out_valid(d_vo), .p(d_p),
    .pcout(d_pc), .overflow(d_ov));

  dsp_mac_pipe #(.A_W(AW), .B_W(BW), .P_W(PW), .M_REG(0), .SATURATE(0)) u_m0 (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(iv), .a(a), .d(d), .b(b),
    .c(c), .pcin(pcin), .mode(mode), .acc_clr(clr), .out_valid(m0_vo), .p(m0_p),
    .pcout(m0_pc), .overflow(m0_ov));

  dsp_mac_pipe #(.A_W(AW), .B_W(BW), .P_W(PW), .M_REG(1), .SATURATE(0)) u_dn (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(dn_iv), .a(dn_a), .d(dn_d),
    .b(dn_b), .c(dn_c), .pcin(d_pc), .mode(dn_mode), .acc_clr(dn_clr),
    .out_valid(dn_vo), .p(dn_p), .pcout(dn_pc), .overflow(dn_ov));

  dsp_mac_pipe #(.A_W(SA), .B_W(SB), .P_W(SP), .M_REG(1), .SATURATE(1)) u_sat1 (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(siv), .a(sa), .d(sd), .b(sb),
    .c(sc), .pcin(spcin), .mode(smode), .acc_clr(sclr), .out_valid(s1_vo),
    .p(s1_p), .pcout(s1_pc), .overflow(s1_ov));

  dsp_mac_pipe #(.A_W(SA), .B_W(SB), .P_W(SP), .M_REG(1), .SATURATE(0)) u_sat0 (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(siv), .a(sa), .d(sd), .b(sb),
    .c(sc), .pcin(spcin), .mode(smode), .acc_clr(sclr), .out_valid(s0_vo),
    .p(s0_p), .pcout(s0_pc), .overflow(s0_ov));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input int m, input logic cl, input longint av, input longint dv,
                         input longint bv, input longint cv);
    iv   = 1'b1;
    mode = 3'(m);
    clr  = cl;
    a    = AW'(av);
    d    = AW'(dv);
    b    = BW'(bv);
    c    = PW'(cv);
  endtask

  typedef struct {
    int     mode;
    logic   clr;
    longint a, d, b, c, pcin;
    longint ep;
    logic   eov;
  } vec_t;

  function automatic vec_t mk(input int m, input logic cl, input longint av, input longint dv,
                              input longint bv, input longint cv, input longint pc,
                              input longint ep, input logic eov);
    vec_t v;
    v.mode = m; v.clr = cl; v.a = av; v.d = dv; v.b = bv; v.c = cv; v.pcin = pc;
    v.ep = ep; v.eov = eov;
    return v;
  endfunction

  localparam longint PMAX = 64'sh0000_7FFF_FFFF_FFFF;
  localparam longint PMIN = -64'sh0000_8000_0000_0000;

  vec_t tv[12];
  int   seen;

  initial begin
    iv = 0; clr = 0; mode = 0; a = '0; d = '0; b = '0; c = '0; pcin = '0;
    dn_iv = 0; dn_clr = 0; dn_mode = 0; dn_a = '0; dn_d = '0; dn_b = '0; dn_c = '0;
    siv = 0; sclr = 0; smode = 0; sa = '0; sd = '0; sb = '0; sc = '0; spcin = '0;

    // sequential table: later entries depend on p left by earlier ones (mode 3)
    tv[0]  = mk(0, 0, 10, -3, 7, -100, 0, -51, 0);           // 7*7-100
    tv[1]  = mk(1, 0, 10, -3, 7, 5, 0, 96, 0);               // 13*7+5
    tv[2]  = mk(2, 0, -6, 99, -11, 77, 1000, 1066, 0);       // 66+pcin, d and c unused
    tv[3]  = mk(3, 1, 9, 0, -9, 0, 0, -81, 0);               // acc_clr: 0 + -81
    tv[4]  = mk(3, 0, 1, 0, 1, 0, 0, -80, 0);                // -81 + 1
    tv[5]  = mk(4, 0, 100, 50, -2, 0, -7, -307, 0);          // 150*-2 + -7
    tv[6]  = mk(0, 1, 4, 4, 4, 0, 0, 32, 0);                 // acc_clr ignored
    tv[7]  = mk(7, 0, 5, 5, 5, -5, 0, -5, 0);                // reserved -> c
    tv[8]  = mk(5, 0, 3, 3, 3, 123456, 99, 123456, 0);       // reserved -> c
    tv[9]  = mk(0, 0, 1, 0, 1, PMAX, 0, PMIN, 1);            // wraps upward
    tv[10] = mk(1, 0, 0, 1, 1, PMIN, 0, PMAX, 1);            // wraps downward
    tv[11] = mk(0, 0, -(64'sd1 <<< 26), -(64'sd1 <<< 26), -(64'sd1 <<< 17), 0, 0,
                64'sd1 <<< 44, 0);                           // extreme pre-adder, not sticky

    // reset state and first-result latency
    repeat (3) tick();
    chk("rst_vo", longint'(d_vo), 0);
    chk("rst_p", longint'(d_p), 0);
    chk("rst_ov", longint'(d_ov), 0);
    chk("rst_sat_p", longint'(s1_p), 0);
    rst = 1'b1;
    enable = 1'b1;
    tick();
    drive_d(0, 0, 5, 3, -4, 100);
    tick();
    iv = 0;
    chk("lat_vo_c1", longint'(d_vo), 0);
    tick();
    chk("lat_vo_c2", longint'(d_vo), 0);
    tick();
    chk("lat_vo_c3", longint'(d_vo), 1);
    chk("lat_p", longint'(d_p), 68);
    chk("lat_pc", longint'(d_pc), 68);
    tick();
    chk("lat_vo_c4", longint'(d_vo), 0);
    chk("lat_p_hold", longint'(d_p), 68);

    // table vectors, one at a time, pipeline fully drained between them
    for (int i = 0; i < 12; i++) begin
      drive_d(tv[i].mode, tv[i].clr, tv[i].a, tv[i].d, tv[i].b, tv[i].c);
      pcin = PW'(tv[i].pcin);
      tick();
      iv = 0;
      tick();
      tick();
      chk($sformatf("vec%0d_vo", i), longint'(d_vo), 1);
      chk($sformatf("vec%0d_p", i), longint'(d_p), tv[i].ep);
      chk($sformatf("vec%0d_ov", i), longint'(d_ov), longint'(tv[i].eov));
    end
    pcin = '0;

    // back-to-back accumulate, then a stall mid-flight
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive_d(3, k == 0, k + 1, 0, 2, 0);
      else iv = 0;
      tick();
      if (k >= 2) begin
        chk($sformatf("acc%0d_vo", k - 2), longint'(d_vo), 1);
        chk($sformatf("acc%0d_p", k - 2), longint'(d_p), (k - 1) * k);
      end
    end
    drive_d(3, 0, 10, 0, 2, 0);
    tick();
    iv = 0;
    enable = 0;
    tick();
    tick();
    chk("stall_p", longint'(d_p), 20);
    chk("stall_vo", longint'(d_vo), 0);
    enable = 1;
    tick();
    chk("resume_vo_early", longint'(d_vo), 0);
    tick();
    chk("resume_vo", longint'(d_vo), 1);
    chk("resume_p", longint'(d_p), 40);

    // cascade: upstream 2*3+1=7, downstream 4*5+7=27 one cycle later
    drive_d(0, 0, 2, 0, 3, 1);
    tick();
    iv = 0;
    dn_iv = 1; dn_mode = 3'd2; dn_a = 27'sd4; dn_b = 18'sd5;
    tick();
    dn_iv = 0;
    tick();
    chk("casc_up_p", longint'(d_pc), 7);
    tick();
    chk("casc_dn_vo", longint'(dn_vo), 1);
    chk("casc_dn_p", longint'(dn_p), 27);

    // M_REG=0: two-cycle latency, subtract and reserved mode
    drive_d(1, 0, -7, 9, 3, 0);
    tick();
    iv = 0;
    chk("m0_vo_c1", longint'(m0_vo), 0);
    tick();
    chk("m0_sub_vo", longint'(m0_vo), 1);
    chk("m0_sub_p", longint'(m0_p), -48);
    drive_d(6, 0, 100, 100, 100, -5);
    tick();
    iv = 0;
    tick();
    chk("m0_rsv_p", longint'(m0_p), -5);
    chk("m0_rsv_ov", longint'(m0_ov), 0);

    // saturation on the narrow slice: 254*127 + 32767 = 65025 exceeds 32767;
    // wrapped result 65025-65536 = -511
    siv = 1; smode = 3'd0; sa = 8'sd127; sd = 8'sd127; sb = 8'sd127; sc = 16'sd32767;
    tick();
    // (-128-127)*127 - 32768 = -65153; wrapped -65153+65536 = 383
    smode = 3'd1; sa = -8'sd128; sd = 8'sd127; sb = 8'sd127; sc = -16'sd32768;
    tick();
    siv = 0;
    tick();
    chk("sat_hi_p", longint'(s1_p), 32767);
    chk("sat_hi_ov", longint'(s1_ov), 1);
    chk("wrap_hi_p", longint'(s0_p), -511);
    chk("wrap_hi_ov", longint'(s0_ov), 1);
    tick();
    chk("sat_lo_p", longint'(s1_p), -32768);
    chk("sat_lo_ov", longint'(s1_ov), 1);
    chk("wrap_lo_p", longint'(s0_p), 383);

    // reset while three operations are in flight
    drive_d(0, 0, 1, 1, 1, 1);
    tick();
    #2;
    rst = 0;
    #1;
    chk("midrst_vo", longint'(d_vo), 0);
    chk("midrst_p", longint'(d_p), 0);
    chk("midrst_ov", longint'(s1_ov) | longint'(d_ov), 0);
    tick();
    tick();
    iv = 0;
    #2;
    rst = 1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (d_vo) seen++;
    end
    chk("midrst_no_result", longint'(seen), 0);
    chk("midrst_p_final", longint'(d_p), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
